// File: rtl/i2c_master_reg16_if.sv
// Request/response and on-chip I2C lines of the 16-bit register write master.
interface i2c_master_reg16_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;

    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              ack_error;
    logic              scl;
    logic              sda_in;
    logic              sda_out;

    // Master: the I2C initiator itself.
    modport master (
        input  start, addr, data, sda_in,
        output busy, done, ack_error, scl, sda_out
    );

    // Slave: the requesting logic plus the I/O buffer feeding sda_in back.
    modport slave (
        output start, addr, data, sda_in,
        input  busy, done, ack_error, scl, sda_out
    );
endinterface

// File: rtl/i2c_master_reg16.sv
// Write-only I2C initiator: START, {addr,W}, data[15:8], data[7:0], STOP.
// Every state phase lasts one quarter-bit of CLK_DIV clocks.
module i2c_master_reg16 #(
    parameter int unsigned CLK_DIV = 60
) (
    input  logic                clk,
    input  logic                reset,
    i2c_master_reg16_if.master  bus
);

    localparam int unsigned QCNT_W  = 10;
    localparam int unsigned SHIFT_W = 24;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned BYTE_W  = 2;
    localparam int unsigned PHASE_W = 2;

    localparam logic [QCNT_W-1:0]  QCNT_LAST = QCNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]   ACK_SLOT  = BIT_W'(8);
    localparam logic [BYTE_W-1:0]  LAST_BYTE = BYTE_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_DONE
    } state_t;

    state_t               state,     state_n;
    logic [QCNT_W-1:0]    qcnt,      qcnt_n;
    logic [PHASE_W-1:0]   phase,     phase_n;
    logic [BIT_W-1:0]     bit_cnt,   bit_cnt_n;
    logic [BYTE_W-1:0]    byte_cnt,  byte_cnt_n;
    logic [SHIFT_W-1:0]   shreg,     shreg_n;
    logic                 scl,       scl_n;
    logic                 sda,       sda_n;
    logic                 busy,      busy_n;
    logic                 done,      done_n;
    logic                 ack_error, ack_error_n;
    logic                 q_last;

    assign q_last = (qcnt == QCNT_LAST);

    // State, counters and all bus-facing outputs register together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            qcnt      <= '0;
            phase     <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            scl       <= 1'b1;
            sda       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
        end else begin
            state     <= state_n;
            qcnt      <= qcnt_n;
            phase     <= phase_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            shreg     <= shreg_n;
            scl       <= scl_n;
            sda       <= sda_n;
            busy      <= busy_n;
            done      <= done_n;
            ack_error <= ack_error_n;
        end
    end

    // Next state, quarter sequencing, and line levels derived from the next state.
    always_comb begin
        state_n     = state;
        qcnt_n      = q_last ? '0 : qcnt + QCNT_W'(1);
        phase_n     = phase;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        shreg_n     = shreg;
        ack_error_n = ack_error;
        scl_n       = 1'b1;
        sda_n       = 1'b1;
        busy_n      = 1'b0;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                qcnt_n = '0;
                if (bus.start) begin
                    state_n     = S_START;
                    phase_n     = '0;
                    bit_cnt_n   = '0;
                    byte_cnt_n  = '0;
                    shreg_n     = {bus.addr, 1'b0, bus.data};
                    ack_error_n = 1'b0;
                end
            end

            S_START: begin
                if (q_last) begin
                    if (phase == PHASE_W'(1)) begin
                        state_n = S_BIT;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + PHASE_W'(1);
                    end
                end
            end

            S_BIT: begin
                // Slave response is taken on the final cycle of the high-going quarter.
                if (bit_cnt == ACK_SLOT && phase == PHASE_W'(2) && q_last && bus.sda_in) begin
                    ack_error_n = 1'b1;
                end
                if (q_last) begin
                    if (phase == PHASE_W'(3)) begin
                        phase_n = '0;
                        if (bit_cnt == ACK_SLOT) begin
                            bit_cnt_n = '0;
                            if (ack_error || byte_cnt == LAST_BYTE) begin
                                state_n = S_STOP;
                            end else begin
                                byte_cnt_n = byte_cnt + BYTE_W'(1);
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + BIT_W'(1);
                            shreg_n   = {shreg[SHIFT_W-2:0], 1'b0};
                        end
                    end else begin
                        phase_n = phase + PHASE_W'(1);
                    end
                end
            end

            S_STOP: begin
                if (q_last) begin
                    if (phase == PHASE_W'(2)) begin
                        state_n = S_DONE;
                        phase_n = '0;
                    end else begin
                        phase_n = phase + PHASE_W'(1);
                    end
                end
            end

            S_DONE: begin
                qcnt_n  = '0;
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
                qcnt_n  = '0;
                phase_n = '0;
            end
        endcase

        case (state_n)
            S_START: begin
                busy_n = 1'b1;
                sda_n  = (phase_n == '0);
            end
            S_BIT: begin
                busy_n = 1'b1;
                scl_n  = phase_n[1];
                sda_n  = (bit_cnt_n == ACK_SLOT) ? 1'b1 : shreg_n[SHIFT_W-1];
            end
            S_STOP: begin
                busy_n = 1'b1;
                scl_n  = (phase_n != '0);
                sda_n  = (phase_n == PHASE_W'(2));
            end
            S_DONE: begin
                done_n = 1'b1;
            end
            default: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
            end
        endcase
    end

    assign bus.scl       = scl;
    assign bus.sda_out   = sda;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.ack_error = ack_error;

endmodule

// File: tb/tb_i2c_master_reg16.sv
// Scoreboard bench for i2c_master_reg16: bus decoder + slave model + reference model.
module tb_i2c_master_reg16;

    localparam int unsigned CLK_DIV = 4;

    typedef struct packed {
        logic [23:0] bytes;
        logic [1:0]  nbytes;
        logic        ack_err;
        logic [15:0] busy_len;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    i2c_master_reg16_if bus();

    i2c_master_reg16 #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    exp_t        exp_q[$];
    int          cur_nack = 3;

    logic [7:0]  got_q[$];
    logic [7:0]  sh;
    int          bitc;
    bit          in_frame;
    int          starts;
    int          stops;
    int unsigned busy_cnt;
    logic        prev_scl;
    logic        prev_sda;
    logic        prev_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bytes a transaction should put on the wire, NACK outcome and busy length.
    function automatic exp_t model(input logic [6:0] a, input logic [15:0] d, input int nk);
        exp_t e;
        int   sent;
        sent       = (nk < 3) ? nk + 1 : 3;
        e.bytes    = {a, 1'b0, d};
        e.nbytes   = 2'(sent);
        e.ack_err  = (nk < 3);
        e.busy_len = 16'((2 + 36 * sent + 3) * CLK_DIV);
        return e;
    endfunction

    // Bus decoder, slave responder and scoreboard check at each done pulse.
    always @(negedge clk) begin
        if (reset) begin
            in_frame   = 1'b0;
            bitc       = 0;
            got_q.delete();
            starts     = 0;
            stops      = 0;
            busy_cnt   = 0;
            bus.sda_in = 1'b1;
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
            prev_done  = 1'b0;
        end else begin
            if (bus.busy) busy_cnt++;

            if (bus.sda_out !== prev_sda) begin
                if (bus.scl && prev_scl) begin
                    if (!bus.sda_out) begin
                        check("start_outside_frame", 32'(in_frame), 0);
                        in_frame = 1'b1;
                        bitc     = 0;
                        starts++;
                    end else begin
                        check("stop_inside_frame", 32'(in_frame), 1);
                        in_frame = 1'b0;
                        stops++;
                    end
                end else begin
                    check("sda_change_only_scl_low", 32'(bus.scl), 0);
                end
            end

            if (in_frame && bus.scl && !prev_scl) begin
                bitc++;
                if (bitc <= 8) begin
                    sh = {sh[6:0], bus.sda_out};
                    if (bitc == 8) got_q.push_back(sh);
                end else begin
                    check("ack_slot_released", 32'(bus.sda_out), 1);
                    bitc = 0;
                end
            end

            if (!bus.scl && prev_scl) begin
                if (in_frame && bitc == 8)
                    bus.sda_in = ((int'(got_q.size()) - 1) == cur_nack);
                else
                    bus.sda_in = 1'b1;
            end

            if (bus.done) begin
                exp_t e;
                check("done_single_cycle", 32'(prev_done), 0);
                check("txn_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("byte_count", got_q.size(), 32'(e.nbytes));
                    for (int i = 0; i < got_q.size() && i < int'(e.nbytes); i++) begin
                        logic [23:0] b;
                        b = e.bytes;
                        check("byte_value", 32'(got_q[i]), 32'(8'(b >> (16 - 8 * i))));
                    end
                    check("start_count", starts, 1);
                    check("stop_count", stops, 1);
                    check("ack_error_at_done", 32'(bus.ack_error), 32'(e.ack_err));
                    check("busy_length", busy_cnt, 32'(e.busy_len));
                    check("busy_low_at_done", 32'(bus.busy), 0);
                end
                got_q.delete();
                starts   = 0;
                stops    = 0;
                busy_cnt = 0;
            end

            prev_done = bus.done;
            prev_scl  = bus.scl;
            prev_sda  = bus.sda_out;
        end
    end

    // One transaction; with hold set, start stays high for back-to-back operation.
    task automatic run_txn(input logic [6:0] a, input logic [15:0] d, input int nk,
                           input bit hold, output int waited);
        exp_t e;
        bit   ok;
        bus.addr  = a;
        bus.data  = d;
        cur_nack  = nk;
        bus.start = 1'b1;
        waited    = 0;
        ok        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            waited++;
            if (bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_seen", 32'(ok), 1);
        if (!ok) begin
            bus.start = 1'b0;
            return;
        end
        e = model(a, d, nk);
        exp_q.push_back(e);
        check("ack_error_cleared_on_accept", 32'(bus.ack_error), 0);
        if (!hold) bus.start = 1'b0;
        bus.addr = 7'($urandom);
        bus.data = 16'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(ok), 1);
        if (!hold && ok) begin
            @(negedge clk);
            check("ack_error_holds", 32'(bus.ack_error), 32'(e.ack_err));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.addr  = '0;
        bus.data  = '0;
        repeat (3) @(negedge clk);
        check("reset_scl", 32'(bus.scl), 1);
        check("reset_sda_out", 32'(bus.sda_out), 1);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_ack_error", 32'(bus.ack_error), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full ACK, NACK on address, NACK on high data byte, then full ACK again.
        run_txn(7'h21, 16'hBEEF, 3, 1'b0, waited);
        repeat (3) @(negedge clk);
        run_txn(7'h21, 16'hBEEF, 0, 1'b0, waited);
        repeat (3) @(negedge clk);
        run_txn(7'h21, 16'hBEEF, 1, 1'b0, waited);
        run_txn(7'h21, 16'hBEEF, 3, 1'b0, waited);

        // start held high: back-to-back transactions two busy-low cycles apart.
        for (int k = 0; k < 4; k++) begin
            run_txn(7'($urandom), 16'($urandom), (k == 2) ? 2 : 3, 1'b1, waited);
            if (k > 0) check("b2b_gap_cycles", waited, 2);
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the second bit of the high data byte.
        bus.addr  = 7'h55;
        bus.data  = 16'hA5C3;
        cur_nack  = 3;
        bus.start = 1'b1;
        for (int i = 0; i < 8 && !bus.busy; i++) @(negedge clk);
        check("busy_before_abort", 32'(bus.busy), 1);
        bus.start = 1'b0;
        repeat ((2 + 36 + 4 + 1) * CLK_DIV) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_scl", 32'(bus.scl), 1);
        check("abort_sda_out", 32'(bus.sda_out), 1);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_txn(7'h55, 16'hA5C3, 3, 1'b0, waited);

        // Randomized traffic with random NACK position.
        for (int k = 0; k < 16; k++) begin
            int nk;
            nk = ($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_txn(7'($urandom), 16'($urandom), nk, 1'b0, waited);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
